// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory read bus between fetch stage and imem
interface fetch_stage_if #(
    parameter int D_WIDTH = 32
);
    logic [D_WIDTH-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    modport master (
        output imem_addr,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC select and IF/ID pipeline register
module fetch_stage #(
    parameter int          D_WIDTH   = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               pcsrc,
    input  logic [D_WIDTH-1:0] jumpaddress,
    fetch_stage_if.master      imem,
    output logic [31:0]        instr_d,
    output logic [D_WIDTH-1:0] prog_addr_d,
    output logic [D_WIDTH-1:0] pcplus4_d,
    output logic               valid_d,
    output logic               flush_d,
    output logic               misalign
);
    logic [D_WIDTH-1:0] r_pc;
    logic [31:0]        r_instr;
    logic [D_WIDTH-1:0] r_prog_addr;
    logic [D_WIDTH-1:0] r_pcplus4;
    logic               r_valid;
    logic               r_misalign;

    logic [D_WIDTH-1:0] w_pc_plus4;
    logic [D_WIDTH-1:0] w_target;
    logic               w_target_misaligned;

    // Low target bits are dropped, not trapped; misalign only records the event.
    assign w_pc_plus4          = r_pc + D_WIDTH'(4);
    assign w_target            = {jumpaddress[D_WIDTH-1:2], 2'b00};
    assign w_target_misaligned = |jumpaddress[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= D_WIDTH'(RESET_PC);
        end else if (pcsrc) begin
            r_pc <= w_target;
        end else if (!stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // A redirect outranks stall: the stalled instruction is younger and wrong-path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= NOP_INSTR;
            r_prog_addr <= '0;
            r_pcplus4   <= '0;
            r_valid     <= 1'b0;
        end else if (pcsrc) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr     <= imem.imem_rdata;
            r_prog_addr <= r_pc;
            r_pcplus4   <= w_pc_plus4;
            r_valid     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (pcsrc && w_target_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign imem.imem_addr = r_pc;
    assign instr_d        = r_instr;
    assign prog_addr_d    = r_prog_addr;
    assign pcplus4_d      = r_pcplus4;
    assign valid_d        = r_valid;
    assign flush_d        = pcsrc;
    assign misalign       = r_misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed vector table plus randomized run against a reference model
module tb_fetch_stage;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] SALT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] jumpaddress = '0;
    logic [31:0] instr_d;
    logic [31:0] prog_addr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        flush_d;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_stage_if #(.D_WIDTH(32)) imem_bus ();
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ SALT;

    fetch_stage #(
        .D_WIDTH  (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pcsrc      (pcsrc),
        .jumpaddress(jumpaddress),
        .imem       (imem_bus),
        .instr_d    (instr_d),
        .prog_addr_d(prog_addr_d),
        .pcplus4_d  (pcplus4_d),
        .valid_d    (valid_d),
        .flush_d    (flush_d),
        .misalign   (misalign)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pcsrc;
        logic [31:0] jump;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pa;
        logic [31:0] e_p4;
        logic        e_valid;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: what decode should see, derived from the fetch rules.
    logic [31:0] m_pc = '0, m_instr = NOP, m_pa = '0, m_p4 = '0;
    logic        m_valid = 1'b0, m_mis = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic r, input logic s, input logic p, input logic [31:0] j,
                        input logic [31:0] a, input logic [31:0] ins, input logic [31:0] pa,
                        input logic [31:0] p4, input logic v, input logic mis);
        vec_t t;
        t.rst = r; t.stall = s; t.pcsrc = p; t.jump = j;
        t.e_addr = a; t.e_instr = ins; t.e_pa = pa; t.e_p4 = p4; t.e_valid = v; t.e_mis = mis;
        vecs.push_back(t);
    endtask

    task automatic model_edge();
        if (rst) begin
            m_pc = '0; m_instr = NOP; m_pa = '0; m_p4 = '0; m_valid = 1'b0; m_mis = 1'b0;
        end else begin
            if (pcsrc && (jumpaddress % 4 != 0)) m_mis = 1'b1;
            if (pcsrc) begin
                m_instr = NOP;
                m_valid = 1'b0;
                m_pc    = jumpaddress - (jumpaddress % 4);
            end else if (!stall) begin
                m_instr = m_pc ^ SALT;
                m_pa    = m_pc;
                m_p4    = m_pc + 32'd4;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    // Inputs are applied just after an edge; outputs are sampled 1 time unit after the next edge.
    task automatic cycle(input logic r, input logic s, input logic p, input logic [31:0] j);
        rst = r; stall = s; pcsrc = p; jumpaddress = j;
        #1;
        chk("flush_d", {31'b0, flush_d}, {31'b0, p});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model();
        chk("rnd imem_addr", imem_bus.imem_addr, m_pc);
        chk("rnd instr_d", instr_d, m_instr);
        chk("rnd prog_addr_d", prog_addr_d, m_pa);
        chk("rnd pcplus4_d", pcplus4_d, m_p4);
        chk("rnd valid_d", {31'b0, valid_d}, {31'b0, m_valid});
        chk("rnd misalign", {31'b0, misalign}, {31'b0, m_mis});
    endtask

    initial begin
        //   rst s  p  jump           addr           instr          pa             p4             v  mis
        addv(1, 0, 0, 32'h0,         32'h0,         NOP,           32'h0,         32'h0,         0, 0);
        addv(1, 0, 0, 32'h0,         32'h0,         NOP,           32'h0,         32'h0,         0, 0);
        addv(0, 0, 0, 32'h0,         32'h4,         32'hA5A5_0000, 32'h0,         32'h4,         1, 0);
        addv(0, 0, 0, 32'h0,         32'h8,         32'hA5A5_0004, 32'h4,         32'h8,         1, 0);
        addv(0, 0, 0, 32'h0,         32'hC,         32'hA5A5_0008, 32'h8,         32'hC,         1, 0);
        addv(0, 0, 0, 32'h0,         32'h10,        32'hA5A5_000C, 32'hC,         32'h10,        1, 0);
        addv(0, 1, 0, 32'h0,         32'h10,        32'hA5A5_000C, 32'hC,         32'h10,        1, 0);
        addv(0, 1, 0, 32'h0,         32'h10,        32'hA5A5_000C, 32'hC,         32'h10,        1, 0);
        addv(0, 1, 0, 32'h0,         32'h10,        32'hA5A5_000C, 32'hC,         32'h10,        1, 0);
        addv(0, 0, 0, 32'h0,         32'h14,        32'hA5A5_0010, 32'h10,        32'h14,        1, 0);
        addv(0, 0, 1, 32'h100,       32'h100,       NOP,           32'h10,        32'h14,        0, 0);
        addv(0, 0, 0, 32'h0,         32'h104,       32'hA5A5_0100, 32'h100,       32'h104,       1, 0);
        addv(0, 1, 1, 32'h40,        32'h40,        NOP,           32'h100,       32'h104,       0, 0);
        addv(0, 0, 1, 32'h203,       32'h200,       NOP,           32'h100,       32'h104,       0, 1);
        addv(0, 0, 0, 32'h0,         32'h204,       32'hA5A5_0200, 32'h200,       32'h204,       1, 1);
        addv(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,           32'h200,       32'h204,       0, 1);
        addv(0, 0, 0, 32'h0,         32'h0,         32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0,         1, 1);
        addv(1, 0, 1, 32'h7,         32'h0,         NOP,           32'h0,         32'h0,         0, 0);
        addv(0, 0, 0, 32'h0,         32'h4,         32'hA5A5_0000, 32'h0,         32'h4,         1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].stall, vecs[i].pcsrc, vecs[i].jump);
            chk($sformatf("v%0d imem_addr", i), imem_bus.imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d instr_d", i), instr_d, vecs[i].e_instr);
            chk($sformatf("v%0d prog_addr_d", i), prog_addr_d, vecs[i].e_pa);
            chk($sformatf("v%0d pcplus4_d", i), pcplus4_d, vecs[i].e_p4);
            chk($sformatf("v%0d valid_d", i), {31'b0, valid_d}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d misalign", i), {31'b0, misalign}, {31'b0, vecs[i].e_mis});
        end

        // Redirect latency: target instruction valid on instr_d two edges after pcsrc.
        cycle(0, 0, 1, 32'h0000_0800);
        cycle(0, 0, 0, 32'h0);
        chk("lat prog_addr_d", prog_addr_d, 32'h800);
        chk("lat instr_d", instr_d, 32'h800 ^ SALT);
        chk("lat valid_d", {31'b0, valid_d}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            logic        r, s, p;
            logic [31:0] j;
            r = ($urandom_range(0, 31) == 0);
            s = ($urandom_range(0, 3) == 0);
            p = ($urandom_range(0, 5) == 0);
            j = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
            cycle(r, s, p, j);
            chk_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
